// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the datapath: opcode,
// memory handshake and stall enable in; mux selects and write strobes out.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
);
  logic                en;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic                branch;
  logic                branch_flip;
  logic [1:0]          pc_source;
  logic                bus_err;
  logic [3:0]          state_o;

  modport master (
    input  en, opcode, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, branch,
           branch_flip, pc_source, bus_err, state_o
  );

  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, branch,
           branch_flip, pc_source, bus_err, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-FSM control unit for a multicycle datapath with memory timeout.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes instead of treating them as nop.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.master bus
);
  localparam int TMO_W = 8;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_I3   = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_BGE  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'b111111);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_ADDR   = 4'd5,  S_MEM_RD = 4'd6,  S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               branch_flip;
    logic [1:0]         pc_source;
  } ctrl_t;

  state_t              state, state_nx;
  logic [OPCODE_W-1:0] opc_q, opc_nx;
  logic [TMO_W-1:0]    tmo_cnt;
  ctrl_t               ctrl_q;
  logic                waiting, timeout, strobe_ok, fetch_gate;

  function automatic state_t decode_target(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R:                           decode_target = S_EXEC_R;
      OP_ADDI, OP_SUBI, OP_I3:        decode_target = S_EXEC_I;
      OP_LW, OP_SW:                   decode_target = S_ADDR;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: decode_target = S_BRANCH;
      OP_J:                           decode_target = S_JUMP;
      OP_NOP:                         decode_target = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      default:                        decode_target = S_TRAP;
`else
      default:                        decode_target = S_FETCH;
`endif
    endcase
  endfunction

  // FETCH carries ir_write/pc_write unconditionally here; mem_ready gates them at the port.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_W'(2'b10); end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_SUBI) ? ALUOP_W'(2'b01) : ALUOP_W'(2'b00);
      end
      S_WB_ALU: begin c.reg_write = 1'b1; c.reg_dst = (op == OP_R); end
      S_ADDR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_WB_MEM: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.branch      = 1'b1;
        c.pc_source   = 2'b01;
        c.alu_op      = (op == OP_BLT || op == OP_BGE) ? ALUOP_W'(2'b11) : ALUOP_W'(2'b01);
        c.branch_flip = (op == OP_BNE) || (op == OP_BLT);
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:  ;
    endcase
    return c;
  endfunction

  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout = waiting && bus.en && !bus.mem_ready && (tmo_cnt == TMO_W'(MEM_TIMEOUT));
  assign opc_nx  = (state == S_DECODE && bus.en) ? bus.opcode : opc_q;

  always_comb begin
    state_nx = state;
    if (bus.en) begin
      case (state)
        S_RST:                                  state_nx = S_FETCH;
        S_FETCH:    if (bus.mem_ready)          state_nx = S_DECODE;
        S_DECODE:                               state_nx = decode_target(bus.opcode);
        S_EXEC_R, S_EXEC_I:                     state_nx = S_WB_ALU;
        S_ADDR:                                 state_nx = (opc_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready)          state_nx = S_WB_MEM;
                    else if (timeout)           state_nx = S_FETCH;
        S_MEM_WR:   if (bus.mem_ready || timeout) state_nx = S_FETCH;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP:   state_nx = S_FETCH;
        S_TRAP:                                 state_nx = S_TRAP;
        default:                                state_nx = S_RST;
      endcase
    end
  end

  // Outputs are registered from the next state; the wait counter restarts on every exit or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      opc_q   <= '0;
      tmo_cnt <= '0;
      ctrl_q  <= '0;
    end else begin
      state  <= state_nx;
      opc_q  <= opc_nx;
      ctrl_q <= ctrl_for(state_nx, opc_nx);
      if (state_nx != state || timeout)
        tmo_cnt <= '0;
      else if (waiting && bus.en && !bus.mem_ready)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign strobe_ok  = bus.en && !timeout;
  assign fetch_gate = (state != S_FETCH) || bus.mem_ready;

  assign bus.pc_write    = ctrl_q.pc_write && strobe_ok && fetch_gate;
  assign bus.ir_write    = ctrl_q.ir_write && strobe_ok && fetch_gate;
  assign bus.mem_read    = ctrl_q.mem_read && strobe_ok;
  assign bus.mem_write   = ctrl_q.mem_write && strobe_ok;
  assign bus.reg_write   = ctrl_q.reg_write && strobe_ok;
  assign bus.branch      = ctrl_q.branch && strobe_ok;
  assign bus.i_or_d      = ctrl_q.i_or_d;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.branch_flip = ctrl_q.branch_flip;
  assign bus.pc_source   = ctrl_q.pc_source;
  assign bus.bus_err     = timeout;
  assign bus.state_o     = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-path model predicts every output each
// cycle, while directed scenarios pin latencies and key strobes with literals.
module tb_multicycle_control_unit;
  localparam int TO = 15;
  localparam logic [5:0] OP_R   = 6'b000000, OP_ADDI = 6'b001000, OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_I3  = 6'b001010, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE  = 6'b000001, OP_BLT  = 6'b000011;
  localparam logic [5:0] OP_BGE = 6'b000101, OP_J    = 6'b000010, OP_NOP  = 6'b111111;
  localparam logic [5:0] OP_ILL = 6'b110000;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   n, errs, rws;

  multicycle_control_unit_if #(.OPCODE_W(6), .ALUOP_W(2)) bus();

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Model: current state number, wait cycles so far, pending states of the instruction.
  int         mcur = 0;
  int         mwait = 0;
  int         path[$];
  logic [5:0] mop = 6'd0;

  task automatic modelAdvance();
    if (!rst_n) begin mcur = 0; mwait = 0; path.delete(); return; end
    if (!bus.en || mcur == 12) return;
    if (mcur == 0) begin mcur = 1; return; end
    if ((mcur == 1 || mcur == 6 || mcur == 7) && !bus.mem_ready) begin
      if (mwait == TO) begin mcur = 1; mwait = 0; path.delete(); end
      else mwait++;
      return;
    end
    mwait = 0;
    if (mcur == 1) path.push_back(2);
    if (mcur == 2) begin
      mop = bus.opcode;
      case (bus.opcode)
        OP_R:                           path = '{3, 8};
        OP_ADDI, OP_SUBI, OP_I3:        path = '{4, 8};
        OP_LW:                          path = '{5, 6, 9};
        OP_SW:                          path = '{5, 7};
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE: path = '{10};
        OP_J:                           path = '{11};
        OP_NOP:                         ;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          path = '{12};
`endif
        end
      endcase
    end
    mcur = (path.size() > 0) ? path.pop_front() : 1;
  endtask

  function automatic logic [21:0] expectFor(input int st, input logic [5:0] op,
                                            input logic e, input logic mr, input int wt);
    logic pcw, irw, iod, mrd, mwr, rd, m2r, rw, asa, br, bf, tmo;
    logic [1:0] asb, aop, pcs;
    {pcw, irw, iod, mrd, mwr, rd, m2r, rw, asa, br, bf} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    tmo = (st == 1 || st == 6 || st == 7) && e && !mr && (wt == TO);
    case (st)
      1:  begin mrd = 1'b1; asb = 2'b01; pcw = mr; irw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1'b1; aop = 2'b10; end
      4:  begin asa = 1'b1; asb = 2'b10; aop = (op == OP_SUBI) ? 2'b01 : 2'b00; end
      5:  begin asa = 1'b1; asb = 2'b10; end
      6:  begin mrd = 1'b1; iod = 1'b1; end
      7:  begin mwr = 1'b1; iod = 1'b1; end
      8:  begin rw = 1'b1; rd = (op == OP_R); end
      9:  begin rw = 1'b1; m2r = 1'b1; end
      10: begin
        asa = 1'b1; br = 1'b1; pcs = 2'b01;
        case (op)
          OP_BEQ:  begin aop = 2'b01; bf = 1'b0; end
          OP_BNE:  begin aop = 2'b01; bf = 1'b1; end
          OP_BLT:  begin aop = 2'b11; bf = 1'b1; end
          default: begin aop = 2'b11; bf = 1'b0; end
        endcase
      end
      11: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    if (!e || tmo) {pcw, irw, mrd, mwr, rw, br} = '0;
    return {pcw, irw, iod, mrd, mwr, rd, m2r, rw, asa, asb, aop, br, bf, pcs, tmo, 4'(st)};
  endfunction

  function automatic logic [21:0] actualVec();
    return {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.branch, bus.branch_flip, bus.pc_source, bus.bus_err, bus.state_o};
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    checkOutput("cycle_outputs", 32'(actualVec()),
                32'(expectFor(mcur, mop, bus.en, bus.mem_ready, mwait)));

  task automatic applyStimulus(input logic e, input logic mr, input logic [5:0] op);
    bus.en = e; bus.mem_ready = mr; bus.opcode = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic runInstr(input string nm, input logic [5:0] op, input int lat);
    int k = 0;
    do begin applyStimulus(1'b1, 1'b1, op); tick(); k++; end
    while (bus.state_o != 4'd1 && k < 40);
    checkOutput(nm, k, lat);
  endtask

  task automatic resetPulse(input string nm);
    rst_n = 1'b0; mcur = 0; mwait = 0; path.delete();
    #1;
    checkOutput(nm, 32'(actualVec()), 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, OP_R);
    tick();
  endtask

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, OP_R);
    checkOutput("rst_outputs", 32'(actualVec()), 0);
    tick(); tick();
    rst_n = 1'b1;

    // R-type with zero-wait memory: 0,1,2,3,8,1
    applyStimulus(1'b1, 1'b1, OP_R);
    checkOutput("t1_rst_state", 32'(bus.state_o), 0);
    tick();
    applyStimulus(1'b1, 1'b1, OP_R);
    checkOutput("t1_fetch", 32'({bus.state_o, bus.ir_write, bus.pc_write, bus.mem_read}), 32'({4'd1, 3'b111}));
    tick(); checkOutput("t1_decode", 32'(bus.state_o), 2);
    tick(); checkOutput("t1_exec_r", 32'({bus.state_o, bus.alu_op}), 32'({4'd3, 2'b10}));
    tick(); checkOutput("t1_wb_alu", 32'({bus.state_o, bus.reg_write, bus.reg_dst}), 32'({4'd8, 2'b11}));
    tick(); checkOutput("t1_back_fetch", 32'(bus.state_o), 1);

    // Load with three wait cycles in MEM_RD
    applyStimulus(1'b1, 1'b1, OP_LW); tick(); tick(); tick();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 3), OP_LW);
      if (bus.state_o == 4'd6 && bus.mem_read && bus.i_or_d) n++;
      tick();
    end
    checkOutput("t2_mem_rd_cycles", n, 4);
    checkOutput("t2_wb_mem", 32'({bus.state_o, bus.reg_write, bus.mem_to_reg}), 32'({4'd9, 2'b11}));
    tick(); checkOutput("t2_back_fetch", 32'(bus.state_o), 1);

    // Branches
    applyStimulus(1'b1, 1'b1, OP_BNE); tick(); tick();
    checkOutput("t3_bne", 32'({bus.state_o, bus.branch, bus.pc_source, bus.alu_op, bus.branch_flip}),
                32'({4'd10, 1'b1, 2'b01, 2'b01, 1'b1}));
    tick(); checkOutput("t3_bne_done", 32'(bus.state_o), 1);
    applyStimulus(1'b1, 1'b1, OP_BGE); tick(); tick();
    checkOutput("t3_bge", 32'({bus.state_o, bus.branch, bus.pc_source, bus.alu_op, bus.branch_flip}),
                32'({4'd10, 1'b1, 2'b01, 2'b11, 1'b0}));
    tick(); checkOutput("t3_bge_done", 32'(bus.state_o), 1);
    runInstr("t3_beq_latency", OP_BEQ, 3);
    runInstr("t3_blt_latency", OP_BLT, 3);

    // Store timeout: 15 idle cycles, abort on the 16th
    applyStimulus(1'b1, 1'b1, OP_SW); tick(); tick(); tick();
    n = 0; errs = 0; rws = 0;
    for (int i = 0; i < 20 && bus.state_o == 4'd7; i++) begin
      applyStimulus(1'b1, 1'b0, OP_SW);
      if (bus.bus_err) errs++;
      n++;
      tick();
      if (bus.reg_write) rws++;
    end
    checkOutput("t4_wr_cycles", n, 16);
    checkOutput("t4_err_pulses", errs, 1);
    checkOutput("t4_no_reg_write", rws, 0);
    checkOutput("t4_after_abort", 32'({bus.state_o, bus.bus_err}), 32'({4'd1, 1'b0}));

    // mem_ready arriving exactly at the limit wins over the abort
    applyStimulus(1'b1, 1'b1, OP_LW); tick(); tick(); tick();
    for (int i = 0; i < TO; i++) begin applyStimulus(1'b1, 1'b0, OP_LW); tick(); end
    applyStimulus(1'b1, 1'b1, OP_LW);
    checkOutput("t4_limit_no_err", 32'({bus.state_o, bus.bus_err, bus.mem_read}), 32'({4'd6, 1'b0, 1'b1}));
    tick(); checkOutput("t4_limit_wb_mem", 32'(bus.state_o), 9);
    tick();

    // Fetch timeout retries FETCH
    errs = 0;
    for (int i = 0; i < TO + 1; i++) begin
      applyStimulus(1'b1, 1'b0, OP_R);
      if (bus.bus_err) errs++;
      tick();
    end
    checkOutput("t4_fetch_timeout", errs, 1);
    checkOutput("t4_fetch_retry", 32'(bus.state_o), 1);

    // Stall: en low in FETCH and mid-EXEC_I
    applyStimulus(1'b0, 1'b1, OP_ADDI);
    checkOutput("t5_fetch_stall", 32'({bus.ir_write, bus.pc_write, bus.mem_read}), 0);
    tick(); checkOutput("t5_fetch_held", 32'(bus.state_o), 1);
    applyStimulus(1'b1, 1'b1, OP_ADDI); tick(); tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, OP_ADDI);
      if (bus.state_o == 4'd4 && {bus.pc_write, bus.ir_write, bus.reg_write,
                                  bus.mem_read, bus.mem_write, bus.branch} == 6'd0) n++;
      tick();
    end
    checkOutput("t5_frozen", n, 5);
    applyStimulus(1'b1, 1'b1, OP_ADDI); tick();
    checkOutput("t5_resume", 32'(bus.state_o), 8);
    tick();

    runInstr("lat_subi", OP_SUBI, 4);
    runInstr("lat_i3", OP_I3, 4);
    runInstr("lat_store", OP_SW, 4);
    runInstr("lat_load", OP_LW, 5);
    runInstr("lat_jump", OP_J, 3);
    runInstr("lat_nop", OP_NOP, 2);

    // Illegal opcode
`ifdef ILLEGAL_TRAP_EN
    applyStimulus(1'b1, 1'b1, OP_ILL); tick(); tick();
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t6_trap_held", 32'(bus.state_o), 12);
    resetPulse("t6_trap_reset");
`else
    runInstr("t6_illegal_nop", OP_ILL, 2);
`endif

    // Asynchronous reset in the middle of MEM_RD
    applyStimulus(1'b1, 1'b1, OP_LW); tick(); tick(); tick();
    applyStimulus(1'b1, 1'b0, OP_LW);
    checkOutput("t6_in_mem_rd", 32'(bus.state_o), 6);
    resetPulse("t6_rst_in_mem_rd");
    checkOutput("t6_restart_fetch", 32'(bus.state_o), 1);
    runInstr("t6_post_reset_r", OP_R, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multicycle successor to the single-cycle opcode decoder; same opcode map, same ALUOp coding.
- Sequences each instruction through a Moore FSM (fetch/decode/execute/memory/writeback) so one ALU and one unified memory are shared.
- Adds a variable-latency memory handshake with timeout and a global stall enable.
- Sits between the instruction register and the datapath muxes and write strobes.

Parameters:
- OPCODE_W, 6, opcode field width; the opcode map occupies the low 6 bits and the upper bits must be 0 for a match.
- ALUOP_W, 2, ALUOp width; the codes 00 add, 01 sub, 10 func, 11 slt are zero-extended.
- MEM_TIMEOUT, 15, number of cycles waited for mem_ready before abort; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; 0 freezes the FSM and the timeout counter
- opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- i_or_d  out  1  memory address select; 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_dst  out  1  write-register select; 1 = rd
- mem_to_reg  out  1  writeback source; 1 = MDR
- reg_write  out  1  register-file write strobe
- alu_src_a  out  1  ALU A select; 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select; 00 rt, 01 const 1, 10 imm, 11 branch offset
- alu_op  out  ALUOP_W  ALU operation class
- branch  out  1  conditional PC write
- branch_flip  out  1  invert the zero flag for the branch condition
- pc_source  out  2  PC input select; 00 ALU, 01 ALUOut, 10 jump target
- bus_err  out  1  one-cycle pulse on memory timeout
- state_o  out  4  current state encoding, for debug

Behaviour:
- State encodings: RST=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11, TRAP=12.
- Reset: asynchronous assertion forces RST, clears the opcode latch and the timeout counter, and drives every output to 0.
- First rising edge after rst_n rises: RST -> FETCH.
- Outputs are decoded from the state and the latched opcode. Exception: ir_write and pc_write in FETCH are additionally gated by mem_ready.
- Every strobe not listed in a state is 0.
- en=0: the state holds and every strobe (pc_write, ir_write, reg_write, mem_read, mem_write, branch) is forced to 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
- DECODE: latches the opcode; alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC_R
  - 001000, 001001, 001010 -> EXEC_I
  - 100011, 101011 -> ADDR
  - 000100, 000001, 000011, 000101 -> BRANCH
  - 000010 -> JUMP
  - 111111 -> FETCH
  - any other opcode -> FETCH (see the optional feature)
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op=01 for subi, 00 otherwise; -> WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0; reg_dst=1 only for R-type; -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, branch=1, pc_source=01; -> FETCH.

  | opcode | alu_op | branch_flip |
  |---|---|---|
  | BEQ | 01 | 0 |
  | BNE | 01 | 1 |
  | BLT | 11 | 1 |
  | BGE | 11 | 0 |

- JUMP: pc_write=1, pc_source=10; -> FETCH.
- Timeout counter:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR while en=1 and mem_ready=0.
  - Cleared on any state change.
  - Reaching MEM_TIMEOUT: bus_err=1 for one cycle, no strobe is issued, and the next state is FETCH (from FETCH the fetch restarts at the same PC).
  - mem_ready=1 in the same cycle the limit is reached: mem_ready wins and bus_err stays 0.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Latency in cycles, with zero-wait memory:
  - R-type, I-type, store: 4
  - load: 5
  - branch, jump: 3
  - nop: 2

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unlisted opcode (or non-zero upper opcode bits) in DECODE goes to TRAP.
  - TRAP drives all strobes to 0 and holds until reset; state_o=12.
- Undefined:
  - An unlisted opcode is treated as nop (DECODE -> FETCH).
  - The TRAP state is unreachable.

Test Plan:
1. Reset, then R-type 000000 with mem_ready tied to 1 -> states 0,1,2,3,8,1. ir_write and pc_write pulse in FETCH; reg_write=1 with reg_dst=1 in WB_ALU; alu_op=10 in EXEC_R.
2. Load 100011, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, i_or_d=1; then WB_MEM with reg_write=1, mem_to_reg=1.
3. BNE 000001 and BGE 000101 -> BRANCH with branch=1, pc_source=01; alu_op/branch_flip = 01/1 and 11/0 respectively; 3 cycles each.
4. mem_ready held 0 in MEM_WR with MEM_TIMEOUT=15 -> bus_err pulses once after 15 cycles, next state FETCH, and mem_write is never followed by reg_write.
5. en=0 for 5 cycles mid-EXEC_I -> state_o stays 4 with all strobes 0; resumes to WB_ALU when en returns to 1.
6. Opcode 110000 -> DECODE then FETCH without the macro; TRAP held until rst_n low with ILLEGAL_TRAP_EN. rst_n pulsed low in MEM_RD -> outputs 0 immediately, state_o=0.
